mips_rtype_sequencer: RTL
=========================

Name: mips_rtype_sequencer

Overview:
Multi-cycle issue controller placed in front of the combinational mips_core R-type datapath. It buffers incoming 32-bit instruction words in a small FIFO and checks each one for a supported R-type encoding. For each legal instruction it drives the word onto the core's instruction input, captures the core result one cycle later, and presents rd/result on a valid/ready writeback port. It also flags illegal encodings and counts retired instructions.

Parameters:
QDEPTH, 4, instruction FIFO depth in entries (power of two, >=2)
CNT_W, 16, width of the retired-instruction counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  instruction word offered
in_instr  input  32  instruction word
in_ready  output  1  FIFO can accept; equals !full
core_instr  output  32  instruction driven to mips_core
core_result  input  32  result from mips_core (combinational in core_instr)
wb_valid  output  1  writeback data valid
wb_rd  output  5  destination register (instr[15:11])
wb_data  output  32  captured core result
wb_ready  input  1  writeback consumer accepts
illegal  output  1  one-cycle pulse: dropped illegal instruction
busy  output  1  FSM not in IDLE, or FIFO non-empty
retired_count  output  CNT_W  retired instructions, wraps modulo 2^CNT_W

Behaviour:
- Reset (async, rst_n=0): FIFO emptied, FSM=IDLE, instr reg=0. core_instr=0, wb_valid=0, wb_rd=0, wb_data=0, illegal=0, retired_count=0, in_ready=1, busy=0. Reset mid-operation abandons the in-flight instruction and all queued instructions with no writeback.
- FIFO: push when in_valid&&in_ready. Pop only by the FSM. A word pushed at edge E is poppable no earlier than edge E+1; no fall-through. Push and pop on the same edge are both honoured, count unchanged. Push is impossible when full because in_ready=0.
- core_instr = instr reg in ISSUE/EXEC/WB, 0x00000000 (NOP) in IDLE.
- Legal means opcode instr[31:26]==0 and funct instr[5:0] is one of 0x20 add, 0x21 addu, 0x22 sub, 0x24 and, 0x25 or, 0x2B sltu, 0x00 sll, 0x02 srl, 0x03 sra. For sll/srl/sra, rs instr[25:21] must also be 0. Anything else is illegal.
- FSM states and transitions:
  - IDLE: FIFO non-empty -> pop into instr reg, go to ISSUE.
  - ISSUE: decode.
    - Illegal -> illegal=1 for this one cycle only, instr dropped, count unchanged, next state IDLE.
    - Legal -> EXEC.
  - EXEC: latch wb_data<=core_result and wb_rd<=instr[15:11].
    - rd==0 -> retired_count++, no writeback; pop next if FIFO non-empty -> ISSUE, else IDLE.
    - rd!=0 -> WB.
  - WB: wb_valid=1. wb_valid, wb_rd and wb_data are held stable until wb_ready.
    - On wb_valid&&wb_ready: retired_count++, wb_valid falls on that edge. Pop next if FIFO non-empty -> ISSUE, else IDLE.
- Latency: word accepted at edge E0 into an empty FIFO with FSM in IDLE gives E1 IDLE->ISSUE, E2 ISSUE->EXEC, E3 EXEC->WB. wb_valid is high after E3. Back-to-back throughput with wb_ready=1 is one instruction per 3 cycles.
- At most one instruction is in flight. Backpressure on wb_ready stalls the FSM in WB while the FIFO keeps filling up to QDEPTH.
- retired_count wraps from 2^CNT_W-1 to 0 with no flag.

Test Plan:
- Reset idle: rst_n=0 then 1, no stimulus -> in_ready=1, busy=0, wb_valid=0, core_instr=0, retired_count=0.
- Single add: push 0x03E1F020 at E0, bench core model returns 0x00000042, wb_ready=1 -> wb_valid high after E3, wb_rd=30, wb_data=0x42, retired_count=1, busy=0 after E4.
- Illegal encodings: push 0x8C010000 (lw), then 0x003FC0C3 (sra with rs=1) -> illegal pulses once for each, wb_valid stays 0, retired_count=0.
- rd=0: push 0x00220020 -> no wb_valid, retired_count increments to 1 after EXEC.
- Backpressure/full: wb_ready=0, push add words continuously -> 5 accepted (1 in flight + 4 queued), in_ready=0 on 6th, wb data stable. Raise wb_ready -> all 5 retire in order, retired_count=5.
- Reset mid-op: 3 queued, rst_n low during EXEC -> all outputs at reset values, no wb_valid after release, retired_count=0.

Source files
------------

// File: rtl/mips_rtype_sequencer.sv
// Multi-cycle issue controller for the combinational mips_core R-type datapath.
// Instruction words queue in a small FIFO and are decoded one at a time. Legal
// words go to the core, and the core result is returned on a valid/ready
// writeback port. Illegal words are dropped with a one-cycle flag.
module mips_rtype_sequencer #(
    parameter int unsigned QDEPTH = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [31:0]      in_instr,
    output logic             in_ready,
    output logic [31:0]      core_instr,
    input  logic [31:0]      core_result,
    output logic             wb_valid,
    output logic [4:0]       wb_rd,
    output logic [31:0]      wb_data,
    input  logic             wb_ready,
    output logic             illegal,
    output logic             busy,
    output logic [CNT_W-1:0] retired_count
);

    localparam int unsigned PTR_W   = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned QCNT_W  = PTR_W + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_EXEC  = 2'd2;
    localparam logic [1:0] S_WB    = 2'd3;

    logic [31:0]       fifo_mem [QDEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [QCNT_W-1:0] q_count;
    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [31:0]       instr_q;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic              legal;
    logic              rd_zero;
    logic              load_wb;
    logic              set_wb;
    logic              clr_wb;
    logic              retire;

    assign full       = (q_count == QCNT_W'(QDEPTH));
    assign empty      = (q_count == '0);
    assign in_ready   = !full;
    assign push       = in_valid && in_ready;
    assign busy       = (state != S_IDLE) || !empty;
    assign core_instr = (state == S_IDLE) ? 32'h0000_0000 : instr_q;
    assign rd_zero    = (instr_q[15:11] == 5'd0);

    // Supported R-type decode; shifts additionally require rs == 0
    always_comb begin
        legal = 1'b0;
        if (instr_q[31:26] == 6'd0) begin
            case (instr_q[5:0])
                6'h20, 6'h21, 6'h22, 6'h24, 6'h25, 6'h2B: legal = 1'b1;
                6'h00, 6'h02, 6'h03:                      legal = (instr_q[25:21] == 5'd0);
                default:                                  legal = 1'b0;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and control decode
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        load_wb   = 1'b0;
        set_wb    = 1'b0;
        clr_wb    = 1'b0;
        retire    = 1'b0;
        illegal   = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (legal) begin
                    state_nxt = S_EXEC;
                end else begin
                    illegal   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_EXEC: begin
                load_wb = 1'b1;
                if (rd_zero) begin
                    retire    = 1'b1;
                    pop       = !empty;
                    state_nxt = empty ? S_IDLE : S_ISSUE;
                end else begin
                    set_wb    = 1'b1;
                    state_nxt = S_WB;
                end
            end
            S_WB: begin
                if (wb_ready) begin
                    clr_wb    = 1'b1;
                    retire    = 1'b1;
                    pop       = !empty;
                    state_nxt = empty ? S_IDLE : S_ISSUE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // FIFO storage; contents are don't-care while the queue is empty
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= in_instr;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   q_count <= q_count + QCNT_W'(1);
                2'b01:   q_count <= q_count - QCNT_W'(1);
                default: q_count <= q_count;
            endcase
        end
    end

    // Instruction register, writeback port and retire counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q       <= '0;
            wb_valid      <= 1'b0;
            wb_rd         <= '0;
            wb_data       <= '0;
            retired_count <= '0;
        end else begin
            if (pop) begin
                instr_q <= fifo_mem[rd_ptr];
            end
            if (load_wb) begin
                wb_data <= core_result;
                wb_rd   <= instr_q[15:11];
            end
            if (set_wb) begin
                wb_valid <= 1'b1;
            end else if (clr_wb) begin
                wb_valid <= 1'b0;
            end
            if (retire) begin
                retired_count <= retired_count + CNT_W'(1);
            end
        end
    end

endmodule
